// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Used by uart_rx now; uart_tx is to be migrated onto the same package.
package uart_pkg;
    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART signal bundle. The slave modport is the receiver and the master modport is the line driver/consumer.
// The parity_err signal exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport slave  (input rx, output data_out, valid, busy, frame_err, parity_err);
    modport master (output rx, input data_out, valid, busy, frame_err, parity_err);
`else
    modport slave  (input rx, output data_out, valid, busy, frame_err);
    modport master (output rx, input data_out, valid, busy, frame_err);
`endif
endinterface

// File: rtl/uart_sync2.sv
// Generic 2-flop synchronizer for asynchronous single-bit inputs.
// RST_VAL sets the value both flops take during reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling. Defining UART_RX_PARITY_EN adds one even-parity bit and the parity_err output.
// A frame ends at mid-stop-bit, so back-to-back frames are accepted.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  io_uart
);
    localparam int              CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   FULL     = CW'(CLKS_PER_BIT);
    localparam logic [2:0]      BIT_LAST = 3'(DATA_BITS - 1);

    uart_state_t          r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_rx_prev;
    logic                 r_stop_bit;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_frame_err;
    logic                 w_rx_s;
    logic                 w_par_bad;

    uart_sync2 #(.RST_VAL(UART_IDLE_LEVEL)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (io_uart.rx),
        .o_q (w_rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
    // Even parity: data bits plus the parity bit must contain an even number of ones.
    assign w_par_bad          = ^{r_shift, r_par_bit};
    assign io_uart.parity_err = r_parity_err;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_data_out  <= '0;
            r_rx_prev   <= UART_IDLE_LEVEL;
            r_stop_bit  <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            r_rx_prev   <= w_rx_s;
            case (r_state)
                IDLE: begin
                    // A true falling edge is required, so a held break cannot restart a frame.
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= DATA;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt     <= '0;
                        r_par_bit <= w_rx_s;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Sample the stop bit at mid-bit, then strobe on the following cycle.
                    if (r_cnt == FULL_M1) begin
                        r_stop_bit <= w_rx_s;
                        r_cnt      <= r_cnt + 1'b1;
                    end else if (r_cnt == FULL) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_frame_err <= !r_stop_bit;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= w_par_bad;
`endif
                        if (r_stop_bit && !w_par_bad) begin
                            r_data_out <= r_shift;
                            r_valid    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_uart.data_out  = r_data_out;
    assign io_uart.valid     = r_valid;
    assign io_uart.busy      = r_busy;
    assign io_uart.frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Each expected strobe goes into a scoreboard when its frame is driven.
// A monitor pops and checks every strobe the receiver produces.
module tb_uart_rx;
    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 10 * C + C / 2 + 3;
`else
    localparam int LAT = 9 * C + C / 2 + 3;
`endif
    // strobe kinds: 0 valid, 1 frame_err, 2 parity_err, 3 frame_err+parity_err, 4 illegal mix
    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_data = 8'h00;
    logic       perr_obs;
    exp_t       sb[$];

    uart_rx_if io ();

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_uart (io)
    );

`ifdef UART_RX_PARITY_EN
    assign perr_obs = io.parity_err;
`else
    assign perr_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        int   k;
        exp_t e;
        cyc++;
        #1;
        if (io.valid === 1'b1 || io.frame_err === 1'b1 || perr_obs === 1'b1) begin
            if (io.valid && (io.frame_err || perr_obs)) k = 4;
            else if (io.valid)                        k = 0;
            else if (io.frame_err && perr_obs)        k = 3;
            else if (io.frame_err)                    k = 1;
            else                                      k = 2;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'(k), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", 32'(k), 32'(e.kind));
                chk("data_out", 32'(io.data_out), 32'(e.data));
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("busy_at_strobe", 32'(io.busy), 32'd0);
            end
        end
    end

    task automatic drive_bit(input logic v);
        io.rx = v;
        repeat (C) @(negedge clk);
    endtask

    // Called on a negedge; the next posedge is the first to sample the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_good);
        exp_t e;
        logic perr;
`ifdef UART_RX_PARITY_EN
        perr = !par_good;
`else
        perr = 1'b0;
`endif
        if (!stop && perr)  e.kind = 3;
        else if (!stop)     e.kind = 1;
        else if (perr)      e.kind = 2;
        else begin
            e.kind   = 0;
            exp_data = d;
        end
        e.data = exp_data;
        e.cyc  = cyc + 1 + LAT;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ !par_good);
`endif
        drive_bit(stop);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        io.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data_out", 32'(io.data_out), 32'h0);
        chk("rst_valid", 32'(io.valid), 32'h0);
        chk("rst_busy", 32'(io.busy), 32'h0);
        chk("rst_frame_err", 32'(io.frame_err), 32'h0);

        // single good frame, busy sampled mid-frame
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                repeat (5 * C) @(negedge clk);
                chk("busy_mid_frame", 32'(io.busy), 32'd1);
            end
        join
        drain(2 * C);
        repeat (2 * C) @(negedge clk);

        // back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        drain(2 * C);
        repeat (2 * C) @(negedge clk);

        // short glitch on the start bit
        io.rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_high", 32'(io.busy), 32'd1);
        io.rx = 1'b1;
        repeat (8) @(negedge clk);
        chk("glitch_busy_drop", 32'(io.busy), 32'd0);
        repeat (2 * C) @(negedge clk);

        // good frame then a framing error
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1);
        io.rx = 1'b1;
        drain(2 * C);
        chk("data_kept_after_ferr", 32'(io.data_out), 32'h11);
        repeat (2 * C) @(negedge clk);

        // break: one frame_err, no restart while rx stays low
        e.kind = 1;
        e.data = exp_data;
        e.cyc  = cyc + 1 + LAT;
        sb.push_back(e);
        io.rx = 1'b0;
        repeat (15 * C) @(negedge clk);
        chk("break_single_ferr", 32'(sb.size()), 32'd0);
        chk("break_no_restart", 32'(io.busy), 32'd0);
        io.rx = 1'b1;
        repeat (2 * C) @(negedge clk);
        send_frame(8'h42, 1'b1, 1'b1);
        drain(2 * C);
        repeat (C) @(negedge clk);

        // reset in the middle of bit 4 of 0x5A, then line returns idle
        io.rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(((8'h5A >> i) & 8'h01) != 8'h00);
        io.rx = 1'b1;
        repeat (C / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        chk("midrst_data_out", 32'(io.data_out), 32'h0);
        chk("midrst_busy", 32'(io.busy), 32'h0);
        chk("midrst_valid", 32'(io.valid), 32'h0);
        repeat (12 * C) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b1);
        drain(2 * C);
        repeat (2 * C) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b0, 1'b0);
        io.rx = 1'b1;
        drain(2 * C);
        chk("data_kept_after_perr", 32'(io.data_out), 32'h07);
        repeat (2 * C) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
